// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control definitions for the single-cycle core: sequencer states
// and the syscall number the decoder treats as program exit.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } run_state_e;

  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [15:0] PAUSE_CNT_MAX = 16'hFFFF;

  // Pause counter sticks at its maximum instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == PAUSE_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous board button, followed by a
// one-cycle rising-edge pulse in the clk domain.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync_meta;
  logic sync_q;
  logic sync_qq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_qq   <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      sync_qq   <= sync_q;
    end
  end

  assign pulse = sync_q & ~sync_qq;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle core: gates the PC write enable,
// pauses on display ecalls until GO, stops on the exit ecall.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             GO,
  input  logic             step_mode,
  input  logic             halt_req,
  input  logic             pause_req,
  input  logic [WIDTH-1:0] led_in,
  output logic             pc_en,
  output logic [WIDTH-1:0] LedData,
  output logic             halted,
  output logic             paused,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [15:0]      pause_cnt
);

  run_state_e state;
  run_state_e next_state;
  logic       go_pulse;
  logic       led_load;
  logic       pause_evt;

  btn_edge_sync u_go_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (GO),
    .pulse (go_pulse)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // pc_en depends only on state and halt_req so the datapath's critical path
  // never sees led_in.
  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    led_load   = 1'b0;
    pause_evt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        pc_en = ~halt_req;
        if (halt_req) begin
          next_state = HALT;
          led_load   = 1'b1;
        end else if (pause_req) begin
          next_state = PAUSE;
          led_load   = 1'b1;
          pause_evt  = 1'b1;
        end else if (step_mode) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (go_pulse) next_state = RUN;
      end
      HALT: begin
        next_state = HALT;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LedData   <= '0;
      instr_cnt <= '0;
      pause_cnt <= '0;
    end else begin
      if (led_load)  LedData   <= led_in;
      if (pc_en)     instr_cnt <= instr_cnt + CNT_W'(1);
      if (pause_evt) pause_cnt <= sat_inc16(pause_cnt);
    end
  end

  assign halted = (state == HALT);
  assign paused = (state == PAUSE);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus random
// episodes compared against a cycle-level behavioural model.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        GO;
  logic        step_mode;
  logic        halt_req;
  logic        pause_req;
  logic [31:0] led_in;
  logic        pc_en;
  logic [31:0] LedData;
  logic        halted;
  logic        paused;
  logic [31:0] instr_cnt;
  logic [15:0] pause_cnt;

  int checks = 0;
  int errors = 0;

  // Model: what the program is doing, plus GO samples seen by the board.
  bit          mRunning, mWaiting, mStopped;
  logic [31:0] mLed, mInstr;
  logic [15:0] mPauses;
  bit          goSeen [3];

  cpu_run_ctrl #(.WIDTH(32), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .GO        (GO),
    .step_mode (step_mode),
    .halt_req  (halt_req),
    .pause_req (pause_req),
    .led_in    (led_in),
    .pc_en     (pc_en),
    .LedData   (LedData),
    .halted    (halted),
    .paused    (paused),
    .instr_cnt (instr_cnt),
    .pause_cnt (pause_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mRunning = 0; mWaiting = 0; mStopped = 0;
    mLed = '0; mInstr = '0; mPauses = '0;
    foreach (goSeen[i]) goSeen[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic modelEdge();
    bit pressed;
    bit retire;
    pressed = goSeen[1] && !goSeen[2];
    retire  = mRunning && !halt_req;
    if (retire) mInstr = mInstr + 32'd1;
    goSeen[2] = goSeen[1];
    goSeen[1] = goSeen[0];
    goSeen[0] = GO;
    if (mStopped) begin
    end else if (mWaiting) begin
      if (pressed) begin mWaiting = 0; mRunning = 1; end
    end else if (mRunning) begin
      if (halt_req) begin
        mRunning = 0; mStopped = 1; mLed = led_in;
      end else if (pause_req) begin
        mRunning = 0; mWaiting = 1; mLed = led_in;
        if (mPauses != 16'hFFFF) mPauses = mPauses + 16'd1;
      end else if (step_mode) begin
        mRunning = 0; mWaiting = 1;
      end
    end else if (start) begin
      mRunning = 1;
    end
  endtask

  task automatic stepCycle();
    #1;
    checkOutput("pc_en", 32'(pc_en), 32'(mRunning && !halt_req));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("halted", 32'(halted), 32'(mStopped));
    checkOutput("paused", 32'(paused), 32'(mWaiting));
    checkOutput("LedData", LedData, mLed);
    checkOutput("instr_cnt", instr_cnt, mInstr);
    checkOutput("pause_cnt", 32'(pause_cnt), 32'(mPauses));
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic p,
                               input logic g, input logic [31:0] led, input int n);
    start = s; halt_req = h; pause_req = p; GO = g; led_in = led;
    repeat (n) stepCycle();
  endtask

  task automatic applyReset();
    rst = 1'b0;
    start = 0; halt_req = 0; pause_req = 0; GO = 0; step_mode = 0; led_in = '0;
    #1;
    modelReset();
    checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
    checkOutput("rst_state", {30'd0, halted, paused}, 32'd0);
    checkOutput("rst_led", LedData, 32'd0);
    checkOutput("rst_instr", instr_cnt, 32'd0);
    checkOutput("rst_pcnt", 32'(pause_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    start = 0; halt_req = 0; pause_req = 0; GO = 0; step_mode = 0; led_in = '0;
    @(negedge clk);

    // Free run for ten cycles
    applyReset();
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 10);
    checkOutput("run10_instr", instr_cnt, 32'd10);
    checkOutput("run10_led", LedData, 32'd0);

    // Display ecall, then resume with a single GO press
    applyStimulus(0, 0, 1, 0, 32'h0000_00AB, 1);
    checkOutput("pause_flag", 32'(paused), 32'd1);
    checkOutput("pause_led", LedData, 32'hAB);
    checkOutput("pause_cnt1", 32'(pause_cnt), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("go_edge2_paused", 32'(paused), 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("go_edge3_paused", 32'(paused), 32'd0);
    checkOutput("resume_instr", instr_cnt, 32'd11);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    // Exit ecall wins over display ecall; nothing leaves HALT but reset
    applyStimulus(0, 1, 1, 0, 32'h55, 1);
    checkOutput("halt_flag", 32'(halted), 32'd1);
    checkOutput("halt_led", LedData, 32'h55);
    checkOutput("halt_pcnt", 32'(pause_cnt), 32'd1);
    applyStimulus(1, 0, 0, 1, 32'h0, 2);
    applyStimulus(0, 0, 0, 0, 32'h0, 5);
    checkOutput("halt_sticky", 32'(halted), 32'd1);
    checkOutput("halt_instr", instr_cnt, 32'd12);

    // Single-step: one initial retire plus one per press
    applyReset();
    step_mode = 1;
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 1, 32'h0, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 5);
    end
    checkOutput("step_instr", instr_cnt, 32'd4);
    checkOutput("step_pcnt", 32'(pause_cnt), 32'd0);
    checkOutput("step_paused", 32'(paused), 32'd1);
    step_mode = 0;

    // GO held high gives one resume; GO glitches while running are ignored
    applyReset();
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 2);
    applyStimulus(0, 0, 1, 0, 32'h1234, 1);
    applyStimulus(0, 0, 0, 1, 32'h0, 20);
    checkOutput("held_paused", 32'(paused), 32'd0);
    checkOutput("held_instr", instr_cnt, 32'd20);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, logic'(k % 2), 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 4);
    checkOutput("glitch_paused", 32'(paused), 32'd0);
    checkOutput("glitch_instr", instr_cnt, 32'd32);

    // Asynchronous reset between edges while running
    @(posedge clk);
    #1;
    checkOutput("prerst_pc_en", 32'(pc_en), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_pc_en", 32'(pc_en), 32'd0);
    checkOutput("midrst_instr", instr_cnt, 32'd0);
    checkOutput("midrst_led", LedData, 32'd0);
    checkOutput("midrst_pcnt", 32'(pause_cnt), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;

    // Retired-instruction counter wraps
    force dut.instr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt;
    mInstr = 32'hFFFF_FFFF;
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("instr_wrap", instr_cnt, 32'd0);

    // Pause counter saturates
    applyReset();
    force dut.pause_cnt = 16'hFFFE;
    #1;
    release dut.pause_cnt;
    mPauses = 16'hFFFE;
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 1, 0, 32'h1, 1);
    checkOutput("pcnt_max", 32'(pause_cnt), 32'h0000_FFFF);
    applyStimulus(0, 0, 0, 1, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 3);
    applyStimulus(0, 0, 1, 0, 32'h2, 1);
    checkOutput("pcnt_sat", 32'(pause_cnt), 32'h0000_FFFF);
    checkOutput("pcnt_sat_led", LedData, 32'h2);

    // Random episodes
    for (int e = 0; e < 10; e++) begin
      applyReset();
      step_mode = logic'($urandom_range(0, 1));
      for (int c = 0; c < 60; c++) begin
        applyStimulus(logic'($urandom_range(0, 3) == 0),
                      logic'($urandom_range(0, 49) == 0),
                      logic'($urandom_range(0, 7) == 0),
                      logic'($urandom_range(0, 2) == 0),
                      32'($urandom), 1);
        if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
